// File: rtl/sprite_cmd_pkg.sv
// Shared definitions for the sprite command dispatcher: command word layout,
// register map, and the dispatcher state encoding.
package sprite_cmd_pkg;

  localparam int SUB_COMP_HI = 31;
  localparam int SUB_COMP_LO = 26;
  localparam int CHILD_HI    = 25;
  localparam int CHILD_LO    = 21;
  localparam int INFO_HI     = 20;
  localparam int INFO_LO     = 17;
  localparam int TYPE_HI     = 16;
  localparam int TYPE_LO     = 14;
  localparam int PP_SEL_BIT  = 13;
  localparam int MSG_HI      = 12;
  localparam int MSG_LO      = 0;

  localparam logic [3:0] INFO_FLIP  = 4'hF;
  localparam logic [3:0] INFO_WRITE = 4'h1;

  localparam logic [1:0] ADDR_CMD    = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CLR    = 2'd2;

  typedef enum logic {IDLE, WAIT_VB} state_t;

  function automatic logic is_flip(input logic [31:0] word);
    return word[INFO_HI:INFO_LO] == INFO_FLIP;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Show-ahead command FIFO: dout always presents the oldest entry while not empty.
module cmd_fifo #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        empty,
  output logic        full,
  output logic [7:0]  level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] DEPTH_L = 8'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    count;
  logic          do_push;
  logic          do_pop;

  // Full is judged before any pop of the same cycle, so a push to a full FIFO is lost.
  assign full    = (count == DEPTH_L);
  assign empty   = (count == 8'd0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 8'd0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 8'd1;
        2'b01:   count <= count - 8'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sprite_cmd_dispatcher.sv
// Avalon-MM command dispatcher: buffers sprite commands and replays them on the
// shared command bus, holding buffer-flip commands until vertical blanking starts.
module sprite_cmd_dispatcher
  import sprite_cmd_pkg::*;
#(
  parameter int DEPTH    = 64,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [1:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  output logic [31:0] cmd_out,
  output logic        frame_flip
);

  localparam logic [9:0] V_ACTIVE_L = 10'(V_ACTIVE);

  state_t      state;
  state_t      state_next;
  logic        push;
  logic        clr;
  logic        status_rd;
  logic        pop;
  logic        flip_issue;
  logic [31:0] head;
  logic        empty;
  logic        full;
  logic [7:0]  level;
  logic        overflow;
  logic [15:0] frame_count;
  logic        vb;
  logic        vb_d;
  logic        vb_start;
  logic        unused_hcount;

  assign unused_hcount = ^hcount;

  assign push      = chipselect & write & (address == ADDR_CMD);
  assign clr       = chipselect & write & (address == ADDR_CLR);
  assign status_rd = chipselect & read  & (address == ADDR_STATUS);

  assign vb       = (vcount >= V_ACTIVE_L);
  assign vb_start = vb & ~vb_d;

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (writedata),
    .dout  (head),
    .empty (empty),
    .full  (full),
    .level (level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!empty && is_flip(head)) state_next = WAIT_VB;
      WAIT_VB: if (vb_start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pop        = 1'b0;
    flip_issue = 1'b0;
    case (state)
      IDLE:    if (!empty && !is_flip(head)) pop = 1'b1;
      WAIT_VB: if (vb_start) begin
        pop        = 1'b1;
        flip_issue = 1'b1;
      end
      default: ;
    endcase
  end

  // vb_d resets high so being reset inside vblank never looks like a blanking edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vb_d        <= 1'b1;
      cmd_out     <= 32'h0;
      frame_flip  <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      vb_d        <= vb;
      cmd_out     <= pop ? head : 32'h0;
      frame_flip  <= flip_issue;
      if (flip_issue) frame_count <= frame_count + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      readdata <= 32'h0;
    end else begin
      if (push && full) overflow <= 1'b1;
      else if (clr)     overflow <= 1'b0;
      if (status_rd)
        readdata <= {overflow, (state == WAIT_VB), 6'b0, level, frame_count};
    end
  end

endmodule

// File: doc/sprite_cmd_dispatcher.md
# sprite_cmd_dispatcher

Avalon-MM slave that accepts 32-bit sprite command words from software, buffers them in a FIFO, and replays them one per clock on a shared command bus that drives every sprite display stage (sub-component ID in bits 31:26). Normal writes are forwarded as soon as possible. Buffer-flip commands (info field = 4'hF) are held until the start of vertical blanking, so the display stages never switch ping/pong buffers mid-frame. Sits between the HPS bridge and all sprite display modules.

## Interface
Parameters:
- DEPTH, 64, FIFO entries; power of two, 2..128
- V_ACTIVE, 480, first vcount value of vertical blanking

Ports:
- clk  input  1  system clock; sole clock domain
- reset  input  1  asynchronous, active-high
- chipselect  input  1  Avalon slave select
- write  input  1  Avalon write strobe
- read  input  1  Avalon read strobe
- address  input  2  word address: 0 = command push, 1 = status, 2 = clear overflow
- writedata  input  32  Avalon write data
- readdata  output  32  status word, registered
- hcount  input  10  current VGA column, from the VGA timing generator
- vcount  input  10  current VGA line, from the VGA timing generator
- cmd_out  output  32  command bus to the sprite display stages; 32'h0 when idle
- frame_flip  output  1  one-cycle pulse, coincident with an issued flip word

## Operation
- Push: chipselect & write & address==0 writes writedata into the FIFO. If the FIFO is full, the word is dropped and overflow is set (sticky).
- Clear: chipselect & write & address==2 clears overflow. If an overflow event occurs in the same cycle, set wins.
- Status read, address 1, readdata updated the cycle after read: [31] overflow, [30] state==WAIT_VB, [29:24] 0, [23:16] FIFO level, [15:0] frame_count.
- Command fields: info = [20:17]. A flip word has info==4'hF. Any other value is forwarded unmodified.
- Vblank start: vb = (vcount >= V_ACTIVE). vb_d is vb registered. vb_start = vb & ~vb_d. hcount is unused beyond the port.
- FSM states:
  - IDLE: if the FIFO is empty, stay.
    - Head is a non-flip word: pop it and drive it on cmd_out next cycle.
    - Head is a flip word: go to WAIT_VB without popping.
  - WAIT_VB: on vb_start, pop the flip word, drive it on cmd_out for one cycle with frame_flip=1, increment frame_count (16-bit, wraps at 65535 -> 0), and return to IDLE. Otherwise hold. Words behind the flip stall, so order is preserved.
- A flip is issued only on a vb_start edge. A flip reaching the head while already inside vblank waits for the next frame. This gives at most one flip per frame.
- Non-flip words behind an issued flip proceed in the following cycles, within the same vblank.
- cmd_out is 32'h0 in every cycle no word is issued. Info 0 is a no-op in the display stages.
- Simultaneous push and pop: both occur and the level is unchanged. A push to a full FIFO while a pop happens in the same cycle is still dropped; full is evaluated before the pop.

## Timing
- Reset values:
  - cmd_out = 0, frame_flip = 0, readdata = 0
  - FIFO empty, overflow = 0, frame_count = 0, state = IDLE
  - vb_d = 1, so no vb_start is seen on the first cycle after reset
- Reset mid-operation discards all buffered words, including a pending flip.
- Latency, empty FIFO and IDLE: push in cycle N, word visible at the FIFO head in N+1, on cmd_out in N+2.
- Throughput: one word per clock in IDLE.
- Flip: vb_start in cycle M puts the flip on cmd_out and frame_flip=1 in M+1. The next word follows no earlier than M+2.
- Each issued word is held on cmd_out for exactly one cycle.

## Structure
- Package sprite_cmd_pkg holds:
  - field bit positions: SUB_COMP 31:26, CHILD 25:21, INFO 20:17, TYPE 16:14, PP_SEL 13, MSG 12:0
  - INFO_FLIP = 4'hF and INFO_WRITE = 4'h1
  - address constants ADDR_CMD, ADDR_STATUS, ADDR_CLR
  - the state enum {IDLE, WAIT_VB}
- Sub-module cmd_fifo: synchronous show-ahead FIFO with parameter DEPTH, width 32, and ports push, pop, din, dout, empty, full, level[7:0].

## Test plan
- Reset, then push 32'h2402_2005, then 32'h2404_0064, with vcount=100 -> cmd_out shows those words in cycles N+2 and N+3, frame_flip=0, then 32'h0.
- Push flip 32'h001E_2000, then write 32'h2402_0005, at vcount=200 -> cmd_out stays 0 and status[30]=1. When vcount goes 479->480: flip on cmd_out with frame_flip=1, next cycle 32'h2402_0005, frame_count=1.
- Push a flip while vcount=490 (inside vblank) -> not issued until the next 479->480 transition.
- Hold vcount=100 so a flip blocks the head, then push DEPTH+3 words -> level=DEPTH, status[31]=1. Write address 2 -> status[31]=0.
- Assert reset while WAIT_VB with 5 words queued -> level=0, cmd_out=0, frame_count=0. Releasing reset with vcount=500 gives no flip and no spurious vb_start.
- Issue 65536 flips, one per frame, using compressed vcount stimulus -> frame_count wraps to 0.
